// File: rtl/md_seq.sv
// Sequential multiply/divide unit owning HI/LO: fixed-latency multiply, restoring divide.
// Build option: define MD_SEQ_MACC_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module md_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  input  logic             stop,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_MUL = 2'd0,
    M_ADD = 2'd1,
    M_SUB = 2'd2
  } mode_t;

  state_t           state_r, state_s;
  mode_t            mode_r, mode_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] opa_r, opa_s;
  logic [WIDTH-1:0] opb_r, opb_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic             sgn_r, sgn_s;
  logic             neg_q_r, neg_q_s;
  logic             neg_r_r, neg_r_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic             busy_r;
  logic             done_r, done_s;
  logic             div0_r, div0_s;

  logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s, acc_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH-1:0]   diff_s, rem_step_s, quo_step_s;
  logic               ge_s;
  logic               div_sgn_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;

  // Datapath: product/accumulate from latched operands, one restoring divide step.
  always_comb begin
    a_ext_s    = sgn_r ? {{WIDTH{opa_r[WIDTH-1]}}, opa_r} : {{WIDTH{1'b0}}, opa_r};
    b_ext_s    = sgn_r ? {{WIDTH{opb_r[WIDTH-1]}}, opb_r} : {{WIDTH{1'b0}}, opb_r};
    prod_s     = a_ext_s * b_ext_s;
    case (mode_r)
      M_ADD:   acc_s = {hi_r, lo_r} + prod_s;
      M_SUB:   acc_s = {hi_r, lo_r} - prod_s;
      default: acc_s = prod_s;
    endcase
    // opa_r holds the dividend bits still to shift in; quotient bits fill from the right.
    shift_s    = {rem_r, opa_r[WIDTH-1]};
    ge_s       = (shift_s >= {1'b0, opb_r});
    diff_s     = shift_s[WIDTH-1:0] - opb_r;
    rem_step_s = ge_s ? diff_s : shift_s[WIDTH-1:0];
    quo_step_s = {opa_r[WIDTH-2:0], ge_s};
    div_sgn_s  = (op == OP_DIV);
    mag_a_s    = (div_sgn_s && da[WIDTH-1]) ? -da : da;
    mag_b_s    = (div_sgn_s && db[WIDTH-1]) ? -db : db;
  end

  // Next-state and next-register computation for the control FSM.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    cnt_s   = cnt_r;
    opa_s   = opa_r;
    opb_s   = opb_r;
    rem_s   = rem_r;
    sgn_s   = sgn_r;
    neg_q_s = neg_q_r;
    neg_r_s = neg_r_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    done_s  = 1'b0;
    div0_s  = 1'b0;
    if (flush) begin
      state_s = S_IDLE;
      cnt_s   = CNT_ZERO;
    end else if (stop) begin
      state_s = state_r;
    end else begin
      case (state_r)
        S_IDLE: begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_s = S_MUL;
              cnt_s   = MUL_LOAD;
              mode_s  = M_MUL;
              sgn_s   = (op == OP_MULT);
              opa_s   = da;
              opb_s   = db;
            end
`ifdef MD_SEQ_MACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_s = S_MUL;
              cnt_s   = MUL_LOAD;
              mode_s  = ((op == OP_MADD) || (op == OP_MADDU)) ? M_ADD : M_SUB;
              sgn_s   = (op == OP_MADD) || (op == OP_MSUB);
              opa_s   = da;
              opb_s   = db;
            end
`endif
            OP_DIV, OP_DIVU: begin
              if (db == {WIDTH{1'b0}}) begin
                div0_s = 1'b1;
              end else begin
                state_s = S_DIV;
                cnt_s   = DIV_LOAD;
                sgn_s   = 1'b0;
                opa_s   = mag_a_s;
                opb_s   = mag_b_s;
                rem_s   = {WIDTH{1'b0}};
                neg_q_s = div_sgn_s && (da[WIDTH-1] ^ db[WIDTH-1]);
                neg_r_s = div_sgn_s && da[WIDTH-1];
              end
            end
            OP_MTHI: begin
              hi_s   = da;
              done_s = 1'b1;
            end
            OP_MTLO: begin
              lo_s   = da;
              done_s = 1'b1;
            end
            default: state_s = S_IDLE;
          endcase
        end
        S_MUL: begin
          if (cnt_r == CNT_ONE) begin
            {hi_s, lo_s} = acc_s;
            done_s       = 1'b1;
            state_s      = S_IDLE;
            cnt_s        = CNT_ZERO;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        S_DIV: begin
          opa_s = quo_step_s;
          rem_s = rem_step_s;
          if (cnt_r == CNT_ONE) begin
            lo_s    = neg_q_r ? -quo_step_s : quo_step_s;
            hi_s    = neg_r_r ? -rem_step_s : rem_step_s;
            done_s  = 1'b1;
            state_s = S_IDLE;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers; synchronous reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      mode_r  <= M_MUL;
      cnt_r   <= CNT_ZERO;
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      sgn_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      div0_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      cnt_r   <= cnt_s;
      opa_r   <= opa_s;
      opb_r   <= opb_s;
      rem_r   <= rem_s;
      sgn_r   <= sgn_s;
      neg_q_r <= neg_q_s;
      neg_r_r <= neg_r_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= done_s;
      div0_r  <= div0_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign div0 = div0_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
